// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames a parallel word as start, LSB-first data,
// optional parity and 1-2 stop bits, one bit per OVERSAMPLE baud tick enables.
module uart_tx_serializer #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 baud_clk_16,
  output logic                 data_out,
  output logic                 busy,
  output logic                 done
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 2 || OVERSAMPLE > 64) begin : g_param_err
    $error("uart_tx_serializer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [TICK_W-1:0]      r_tick_cnt;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic                   r_stop_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_parity;
  logic                   r_done;
  logic                   w_bit_end;
  logic                   w_accept;
  logic                   w_frame_end;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY_MODE == 2) ? ~^d : ^d;
  endfunction

  assign w_bit_end = baud_clk_16 && (r_tick_cnt == TICK_LAST);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Line level is decoded from state so an async reset returns it to mark at once.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_frame_end = 1'b0;
    data_out    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_accept = 1'b1;
          w_next   = S_START;
        end
      end
      S_START: begin
        data_out = 1'b0;
        if (w_bit_end) w_next = S_DATA;
      end
      S_DATA: begin
        data_out = r_shift[0];
        if (w_bit_end && r_bit_cnt == BIT_LAST)
          w_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        data_out = r_parity;
        if (w_bit_end) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end && r_stop_cnt == STOP_LAST) begin
          w_next      = S_IDLE;
          w_frame_end = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      if (w_accept) begin
        r_tick_cnt <= '0;
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
      end else if (baud_clk_16 && r_state != S_IDLE) begin
        r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + TICK_W'(1);
        if (w_bit_end && r_state == S_DATA) r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
        if (w_bit_end && r_state == S_STOP) r_stop_cnt <= r_stop_cnt + 1'b1;
      end
    end
  end

  // Payload registers carry no reset; they are always reloaded on accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift  <= data_in;
      r_parity <= parity_of(data_in);
    end else if (r_state == S_DATA && w_bit_end) begin
      r_shift <= r_shift >> 1;
    end
  end

endmodule
